msrv32_trap_sequencer: RTL and testbench
========================================

# msrv32_trap_sequencer

Multi-cycle trap entry/return sequencer for the msrv32 core. It arbitrates a decoded synchronous exception, pending machine interrupts, and MRET, then issues CSR write strobes (mepc, mcause, mtval) one per cycle. It redirects the PC to the trap vector or to mepc, and stalls the pipeline for the duration. It sits between decode/execute (exception sources), the machine CSR file (mie/mip/mtvec/mepc), and the PC mux.

## Interface

Parameters:
- VECTORED, 0: 1 enables vectored interrupt targets (base + 4*cause); exceptions always use base.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - ms_riscv32_mp_clk_in  in  1  core clock.
  - ms_riscv32_mp_rst_in  in  1  reset, synchronous, active-high.
- Exception and MRET inputs:
  - exc_valid_in  in  1  synchronous exception present this cycle.
  - exc_cause_in  in  4  exception cause code (0,2,4,6,...).
  - exc_tval_in  in  32  faulting address/instruction for mtval.
  - mret_in  in  1  MRET retiring this cycle.
  - pc_in  in  32  PC of the current instruction.
- Interrupt and CSR inputs:
  - mie_in  in  1  mstatus.MIE.
  - meie_in, mtie_in, msie_in  in  1 each  mie enables.
  - meip_in, mtip_in, msip_in  in  1 each  mip pending (level).
  - mtvec_in  in  32  trap base; bits [1:0] ignored.
  - mepc_in  in  32  current mepc for MRET.
- Outputs:
  - busy_out  out  1  pipeline stall; high in every non-IDLE state.
  - flush_out  out  1  one-cycle pipeline flush pulse.
  - csr_we_mepc_out, csr_we_mcause_out, csr_we_mtval_out  out  1 each  CSR write strobes.
  - csr_wdata_out  out  32  data for the asserted strobe.
  - mie_clear_out, mie_set_out  out  1 each  mstatus.MIE clear (trap entry) / set (MRET).
  - pc_redirect_out  out  1  load PC from pc_target_out.
  - pc_target_out  out  32  redirect target.
  - trap_taken_out  out  1  one-cycle pulse at trap redirect.

## Operation

- State machine: IDLE, W_EPC, W_CAUSE, W_TVAL, REDIRECT, RET.
- Sampling in IDLE: inputs are sampled only in IDLE and ignored in all other states. Priority order:
  - exc_valid_in, then
  - interrupt (mie_in and any enable&pending), then
  - mret_in.
- Interrupt priority: MEI (11) > MSI (3) > MTI (7).
- Trap capture (on accept):
  - Latch epc = {pc_in[31:2],2'b00}.
  - Latch cause; latch irq flag (1 for interrupt).
  - Latch tval = exc_tval_in for an exception, 0 for an interrupt.
  - Go to W_EPC.
- W_EPC:
  - csr_we_mepc_out=1, wdata=epc, flush_out=1.
  - Next state W_CAUSE.
- W_CAUSE:
  - csr_we_mcause_out=1, wdata={irq,27'b0,cause}, mie_clear_out=1.
  - Next state W_TVAL.
- W_TVAL:
  - csr_we_mtval_out=1, wdata=tval.
  - Next state REDIRECT.
- REDIRECT:
  - pc_redirect_out=1, trap_taken_out=1.
  - Target = base = {mtvec_in[31:2],2'b00}; if VECTORED and irq, target = base + {26'b0,cause,2'b00} (32-bit wrap).
  - Next state IDLE.
- MRET accept leads to RET:
  - mie_set_out=1, flush_out=1, pc_redirect_out=1, target={mepc_in[31:2],2'b00}.
  - Next state IDLE.
- Output defaults: all strobes/pulses are 0 and csr_wdata_out/pc_target_out are 0 in any state not driving them.

## Timing

- All outputs are registered Moore decodes of state and latched data. Event sampled at edge T: first strobe is visible after T+1.
- Trap sequence: W_EPC at T+1, W_CAUSE T+2, W_TVAL T+3, REDIRECT T+4, IDLE T+5. busy_out high T+1..T+4.
- MRET: RET at T+1, IDLE at T+2.
- Back-to-back:
  - A new event is accepted in the first IDLE cycle (T+5).
  - A level interrupt still pending after entry does not retrigger while mie_in is 0.
- Simultaneous events:
  - exc + irq: exception wins.
  - exc + mret: exception wins.
  - irq + mret: interrupt wins; MRET is not performed and is re-executed after return.
- Reset (synchronous, any state, including mid-sequence):
  - Next state IDLE; all outputs 0; latched epc/cause/tval/irq cleared.
  - Any incomplete CSR write sequence is abandoned.

## Structure

- Package msrv32_trap_pkg holds:
  - state enum;
  - cause constants (MEI=11, MSI=3, MTI=7, ILLEGAL=2, MIS_INSTR=0, MIS_LOAD=4, MIS_STORE=6);
  - mcause interrupt bit position (31).
- Sub-module msrv32_irq_priority: combinational encoder (mie, enables, pendings) -> irq_valid, irq_cause[3:0].

## Test plan

- Exception entry: exc_valid_in=1, cause=2, tval=0x00000013, pc_in=0x00000104, mtvec_in=0x00000201. Expect:
  - mepc write 0x00000104;
  - mcause write 0x00000002;
  - mtval write 0x00000013;
  - redirect to 0x00000200 at T+4;
  - busy high 4 cycles.
- Vectored timer interrupt: VECTORED=1, mie=1, mtie=mtip=1, mtvec_in=0x00001000. Expect:
  - mcause 0x80000007;
  - mtval 0;
  - target 0x0000101C;
  - mie_clear at T+2.
- Priority: all three interrupts pending and enabled, plus exc_valid_in=1, cause=6. Expect mcause 6. Then, with exception removed, MRET, mie_in=1 -> mcause 0x8000000B.
- MRET: mret_in=1, mepc_in=0x00000403. Expect at T+1: mie_set=1, redirect to 0x00000400, busy=1; IDLE at T+2.
- Reset mid-sequence: assert reset in W_CAUSE. Expect:
  - all outputs 0 next cycle;
  - no mtval write;
  - a fresh exception then runs the full 4-cycle sequence.
- Inputs ignored while busy: exc_valid_in pulsed during W_EPC..REDIRECT. Expect no second sequence and no wdata change.

Source files
------------

// File: rtl/msrv32_trap_pkg.sv
// Shared encodings for the msrv32 trap sequencer: FSM states, trap cause codes
// and helpers that build the architectural CSR/PC values.
package msrv32_trap_pkg;

    typedef logic [2:0] trap_state_t;

    localparam trap_state_t ST_IDLE     = 3'd0;
    localparam trap_state_t ST_W_EPC    = 3'd1;
    localparam trap_state_t ST_W_CAUSE  = 3'd2;
    localparam trap_state_t ST_W_TVAL   = 3'd3;
    localparam trap_state_t ST_REDIRECT = 3'd4;
    localparam trap_state_t ST_RET      = 3'd5;

    localparam logic [3:0] CAUSE_MIS_INSTR = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_MIS_LOAD  = 4'd4;
    localparam logic [3:0] CAUSE_MIS_STORE = 4'd6;
    localparam logic [3:0] CAUSE_MSI       = 4'd3;
    localparam logic [3:0] CAUSE_MTI       = 4'd7;
    localparam logic [3:0] CAUSE_MEI       = 4'd11;

    localparam int MCAUSE_IRQ_BIT = 31;

    // PC-type values are word aligned; the low two bits are always discarded.
    function automatic logic [31:0] align4(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] mcause_word(input logic irq, input logic [3:0] cause);
        logic [31:0] word;
        word = {28'd0, cause};
        word[MCAUSE_IRQ_BIT] = irq;
        return word;
    endfunction

endpackage

// File: rtl/msrv32_irq_priority.sv
// Fixed-priority machine interrupt encoder: MEI over MSI over MTI, all gated
// by the global mstatus.MIE enable.
module msrv32_irq_priority
    import msrv32_trap_pkg::*;
(
    input  logic       mie,
    input  logic       meie,
    input  logic       mtie,
    input  logic       msie,
    input  logic       meip,
    input  logic       mtip,
    input  logic       msip,
    output logic       irq_valid,
    output logic [3:0] irq_cause
);

    always_comb begin
        irq_valid = 1'b0;
        irq_cause = 4'd0;
        if (mie) begin
            if (meie && meip) begin
                irq_valid = 1'b1;
                irq_cause = CAUSE_MEI;
            end else if (msie && msip) begin
                irq_valid = 1'b1;
                irq_cause = CAUSE_MSI;
            end else if (mtie && mtip) begin
                irq_valid = 1'b1;
                irq_cause = CAUSE_MTI;
            end
        end
    end

endmodule

// File: rtl/msrv32_trap_sequencer.sv
// Trap entry / MRET sequencer: writes mepc, mcause, mtval on consecutive cycles,
// then redirects the PC, stalling the pipeline throughout.
module msrv32_trap_sequencer
    import msrv32_trap_pkg::*;
#(
    parameter bit VECTORED = 1'b0
)
(
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        exc_valid_in,
    input  logic [3:0]  exc_cause_in,
    input  logic [31:0] exc_tval_in,
    input  logic        mret_in,
    input  logic [31:0] pc_in,
    input  logic        mie_in,
    input  logic        meie_in,
    input  logic        mtie_in,
    input  logic        msie_in,
    input  logic        meip_in,
    input  logic        mtip_in,
    input  logic        msip_in,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    output logic        busy_out,
    output logic        flush_out,
    output logic        csr_we_mepc_out,
    output logic        csr_we_mcause_out,
    output logic        csr_we_mtval_out,
    output logic [31:0] csr_wdata_out,
    output logic        mie_clear_out,
    output logic        mie_set_out,
    output logic        pc_redirect_out,
    output logic [31:0] pc_target_out,
    output logic        trap_taken_out
);

    trap_state_t state, state_nx;
    logic [31:0] epc, epc_nx;
    logic [31:0] tval, tval_nx;
    logic [3:0]  cause, cause_nx;
    logic        irq, irq_nx;

    logic        irq_valid;
    logic [3:0]  irq_cause;

    logic        busy_d, flush_d, we_mepc_d, we_mcause_d, we_mtval_d;
    logic        mie_clear_d, mie_set_d, redirect_d, trap_taken_d;
    logic [31:0] wdata_d, target_d;

    msrv32_irq_priority u_irq_priority (
        .mie       (mie_in),
        .meie      (meie_in),
        .mtie      (mtie_in),
        .msie      (msie_in),
        .meip      (meip_in),
        .mtip      (mtip_in),
        .msip      (msip_in),
        .irq_valid (irq_valid),
        .irq_cause (irq_cause)
    );

    // Requests are only looked at in IDLE; the other states walk a fixed path.
    always_comb begin
        state_nx = state;
        epc_nx   = epc;
        tval_nx  = tval;
        cause_nx = cause;
        irq_nx   = irq;
        case (state)
            ST_IDLE: begin
                if (exc_valid_in) begin
                    epc_nx   = align4(pc_in);
                    cause_nx = exc_cause_in;
                    irq_nx   = 1'b0;
                    tval_nx  = exc_tval_in;
                    state_nx = ST_W_EPC;
                end else if (irq_valid) begin
                    epc_nx   = align4(pc_in);
                    cause_nx = irq_cause;
                    irq_nx   = 1'b1;
                    tval_nx  = 32'd0;
                    state_nx = ST_W_EPC;
                end else if (mret_in) begin
                    state_nx = ST_RET;
                end
            end
            ST_W_EPC:    state_nx = ST_W_CAUSE;
            ST_W_CAUSE:  state_nx = ST_W_TVAL;
            ST_W_TVAL:   state_nx = ST_REDIRECT;
            ST_REDIRECT: state_nx = ST_IDLE;
            ST_RET:      state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        busy_d       = 1'b0;
        flush_d      = 1'b0;
        we_mepc_d    = 1'b0;
        we_mcause_d  = 1'b0;
        we_mtval_d   = 1'b0;
        mie_clear_d  = 1'b0;
        mie_set_d    = 1'b0;
        redirect_d   = 1'b0;
        trap_taken_d = 1'b0;
        wdata_d      = 32'd0;
        target_d     = 32'd0;
        case (state_nx)
            ST_W_EPC: begin
                busy_d    = 1'b1;
                flush_d   = 1'b1;
                we_mepc_d = 1'b1;
                wdata_d   = epc_nx;
            end
            ST_W_CAUSE: begin
                busy_d      = 1'b1;
                we_mcause_d = 1'b1;
                mie_clear_d = 1'b1;
                wdata_d     = mcause_word(irq_nx, cause_nx);
            end
            ST_W_TVAL: begin
                busy_d     = 1'b1;
                we_mtval_d = 1'b1;
                wdata_d    = tval_nx;
            end
            ST_REDIRECT: begin
                busy_d       = 1'b1;
                redirect_d   = 1'b1;
                trap_taken_d = 1'b1;
                target_d     = align4(mtvec_in);
                if (VECTORED && irq_nx) begin
                    target_d = align4(mtvec_in) + {26'd0, cause_nx, 2'b00};
                end
            end
            ST_RET: begin
                busy_d     = 1'b1;
                flush_d    = 1'b1;
                mie_set_d  = 1'b1;
                redirect_d = 1'b1;
                target_d   = align4(mepc_in);
            end
            default: ;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state             <= ST_IDLE;
            epc               <= 32'd0;
            tval              <= 32'd0;
            cause             <= 4'd0;
            irq               <= 1'b0;
            busy_out          <= 1'b0;
            flush_out         <= 1'b0;
            csr_we_mepc_out   <= 1'b0;
            csr_we_mcause_out <= 1'b0;
            csr_we_mtval_out  <= 1'b0;
            csr_wdata_out     <= 32'd0;
            mie_clear_out     <= 1'b0;
            mie_set_out       <= 1'b0;
            pc_redirect_out   <= 1'b0;
            pc_target_out     <= 32'd0;
            trap_taken_out    <= 1'b0;
        end else begin
            state             <= state_nx;
            epc               <= epc_nx;
            tval              <= tval_nx;
            cause             <= cause_nx;
            irq               <= irq_nx;
            busy_out          <= busy_d;
            flush_out         <= flush_d;
            csr_we_mepc_out   <= we_mepc_d;
            csr_we_mcause_out <= we_mcause_d;
            csr_we_mtval_out  <= we_mtval_d;
            csr_wdata_out     <= wdata_d;
            mie_clear_out     <= mie_clear_d;
            mie_set_out       <= mie_set_d;
            pc_redirect_out   <= redirect_d;
            pc_target_out     <= target_d;
            trap_taken_out    <= trap_taken_d;
        end
    end

endmodule

// File: tb/tb_msrv32_trap_sequencer.sv
// Bench for msrv32_trap_sequencer: a non-vectored and a vectored instance share
// stimulus and are compared every cycle against a trap-rule reference model.
module tb_msrv32_trap_sequencer;

    typedef struct packed {
        logic        busy;
        logic        flush;
        logic        we_mepc;
        logic        we_mcause;
        logic        we_mtval;
        logic [31:0] wdata;
        logic        mie_clear;
        logic        mie_set;
        logic        redirect;
        logic [31:0] target;
        logic        trap_taken;
    } obs_t;

    typedef struct packed {
        obs_t v0;
        obs_t v1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exc_valid = 1'b0;
    logic [3:0]  exc_cause = 4'd0;
    logic [31:0] exc_tval = 32'd0;
    logic        mret = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        mie = 1'b0;
    logic        meie = 1'b0, mtie = 1'b0, msie = 1'b0;
    logic        meip = 1'b0, mtip = 1'b0, msip = 1'b0;
    logic [31:0] mtvec = 32'd0;
    logic [31:0] mepc = 32'd0;

    logic        o0_busy, o0_flush, o0_we_mepc, o0_we_mcause, o0_we_mtval;
    logic        o0_mie_clear, o0_mie_set, o0_redirect, o0_trap_taken;
    logic [31:0] o0_wdata, o0_target;
    logic        o1_busy, o1_flush, o1_we_mepc, o1_we_mcause, o1_we_mtval;
    logic        o1_mie_clear, o1_mie_set, o1_redirect, o1_trap_taken;
    logic [31:0] o1_wdata, o1_target;

    obs_t obs0, obs1;
    assign obs0 = {o0_busy, o0_flush, o0_we_mepc, o0_we_mcause, o0_we_mtval, o0_wdata,
                   o0_mie_clear, o0_mie_set, o0_redirect, o0_target, o0_trap_taken};
    assign obs1 = {o1_busy, o1_flush, o1_we_mepc, o1_we_mcause, o1_we_mtval, o1_wdata,
                   o1_mie_clear, o1_mie_set, o1_redirect, o1_target, o1_trap_taken};

    always #5 clk = ~clk;

    msrv32_trap_sequencer #(.VECTORED(1'b0)) dut0 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .exc_valid_in         (exc_valid),
        .exc_cause_in         (exc_cause),
        .exc_tval_in          (exc_tval),
        .mret_in              (mret),
        .pc_in                (pc),
        .mie_in               (mie),
        .meie_in              (meie),
        .mtie_in              (mtie),
        .msie_in              (msie),
        .meip_in              (meip),
        .mtip_in              (mtip),
        .msip_in              (msip),
        .mtvec_in             (mtvec),
        .mepc_in              (mepc),
        .busy_out             (o0_busy),
        .flush_out            (o0_flush),
        .csr_we_mepc_out      (o0_we_mepc),
        .csr_we_mcause_out    (o0_we_mcause),
        .csr_we_mtval_out     (o0_we_mtval),
        .csr_wdata_out        (o0_wdata),
        .mie_clear_out        (o0_mie_clear),
        .mie_set_out          (o0_mie_set),
        .pc_redirect_out      (o0_redirect),
        .pc_target_out        (o0_target),
        .trap_taken_out       (o0_trap_taken)
    );

    msrv32_trap_sequencer #(.VECTORED(1'b1)) dut1 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .exc_valid_in         (exc_valid),
        .exc_cause_in         (exc_cause),
        .exc_tval_in          (exc_tval),
        .mret_in              (mret),
        .pc_in                (pc),
        .mie_in               (mie),
        .meie_in              (meie),
        .mtie_in              (mtie),
        .msie_in              (msie),
        .meip_in              (meip),
        .mtip_in              (mtip),
        .msip_in              (msip),
        .mtvec_in             (mtvec),
        .mepc_in              (mepc),
        .busy_out             (o1_busy),
        .flush_out            (o1_flush),
        .csr_we_mepc_out      (o1_we_mepc),
        .csr_we_mcause_out    (o1_we_mcause),
        .csr_we_mtval_out     (o1_we_mtval),
        .csr_wdata_out        (o1_wdata),
        .mie_clear_out        (o1_mie_clear),
        .mie_set_out          (o1_mie_set),
        .pc_redirect_out      (o1_redirect),
        .pc_target_out        (o1_target),
        .trap_taken_out       (o1_trap_taken)
    );

    int   n_checks = 0;
    int   n_pass = 0;
    bit   idle_now = 1'b1;
    exp_t exp_q[$];

    // Reference: decide the accepted event from the trap rules and queue the
    // per-cycle output pattern it must produce.
    task automatic model_accept();
        logic [3:0]  prio_cause [3];
        logic        hit [3];
        logic [3:0]  cause;
        logic        is_irq;
        logic [31:0] tval, base;
        int          pick;
        exp_t        e;
        prio_cause = '{4'd11, 4'd3, 4'd7};
        hit[0] = meie & meip;
        hit[1] = msie & msip;
        hit[2] = mtie & mtip;
        pick = -1;
        for (int i = 0; i < 3; i++) if (pick < 0 && hit[i]) pick = i;
        base = mtvec & 32'hFFFF_FFFC;
        if (exc_valid) begin
            cause = exc_cause; is_irq = 1'b0; tval = exc_tval;
        end else if (mie && pick >= 0) begin
            cause = prio_cause[pick]; is_irq = 1'b1; tval = 32'd0;
        end else if (mret) begin
            e = '0;
            e.v0.busy = 1'b1; e.v0.mie_set = 1'b1; e.v0.flush = 1'b1;
            e.v0.redirect = 1'b1; e.v0.target = mepc & 32'hFFFF_FFFC;
            e.v1 = e.v0;
            exp_q.push_back(e);
            return;
        end else begin
            return;
        end
        e = '0;
        e.v0.busy = 1'b1; e.v0.flush = 1'b1; e.v0.we_mepc = 1'b1;
        e.v0.wdata = pc & 32'hFFFF_FFFC;
        e.v1 = e.v0;
        exp_q.push_back(e);
        e = '0;
        e.v0.busy = 1'b1; e.v0.we_mcause = 1'b1; e.v0.mie_clear = 1'b1;
        e.v0.wdata = (is_irq ? 32'h8000_0000 : 32'd0) + 32'(cause);
        e.v1 = e.v0;
        exp_q.push_back(e);
        e = '0;
        e.v0.busy = 1'b1; e.v0.we_mtval = 1'b1; e.v0.wdata = tval;
        e.v1 = e.v0;
        exp_q.push_back(e);
        e = '0;
        e.v0.busy = 1'b1; e.v0.redirect = 1'b1; e.v0.trap_taken = 1'b1;
        e.v0.target = base;
        e.v1 = e.v0;
        if (is_irq) e.v1.target = base + 32'(cause) * 32'd4;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input obs_t got, input obs_t want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, want);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        if (rst) exp_q.delete();
        else if (idle_now) model_accept();
        @(posedge clk);
        @(negedge clk);
        if (rst || exp_q.size() == 0) begin
            e = '0;
            idle_now = 1'b1;
        end else begin
            e = exp_q.pop_front();
            idle_now = 1'b0;
        end
        check({tag, "/v0"}, obs0, e.v0);
        check({tag, "/v1"}, obs1, e.v1);
    endtask

    task automatic quiet();
        exc_valid = 1'b0; exc_cause = 4'd0; exc_tval = 32'd0; mret = 1'b0; pc = 32'd0;
        mie = 1'b0; meie = 1'b0; mtie = 1'b0; msie = 1'b0;
        meip = 1'b0; mtip = 1'b0; msip = 1'b0;
    endtask

    // Noise on every request input; mtvec/mepc stay put as a CSR file would.
    task automatic junk();
        exc_valid = 1'($urandom); exc_cause = 4'($urandom); exc_tval = $urandom;
        mret = 1'($urandom); pc = $urandom; mie = 1'($urandom);
        meie = 1'($urandom); mtie = 1'($urandom); msie = 1'($urandom);
        meip = 1'($urandom); mtip = 1'($urandom); msip = 1'($urandom);
    endtask

    task automatic random_event();
        int r;
        r = $urandom_range(0, 7);
        quiet();
        mtvec = $urandom;
        mepc = $urandom;
        pc = $urandom;
        exc_cause = 4'($urandom);
        exc_tval = $urandom;
        mie = 1'($urandom);
        meie = 1'($urandom); mtie = 1'($urandom); msie = 1'($urandom);
        meip = 1'($urandom); mtip = 1'($urandom); msip = 1'($urandom);
        exc_valid = (r < 3);
        mret = (r >= 2 && r < 6);
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        tick("reset");
        rst = 1'b0;
        tick("idle_after_reset");

        // Exception entry
        exc_valid = 1'b1; exc_cause = 4'd2; exc_tval = 32'h0000_0013;
        pc = 32'h0000_0104; mtvec = 32'h0000_0201;
        tick("exc_mepc");
        junk(); tick("exc_mcause");
        junk(); tick("exc_mtval");
        junk(); tick("exc_redirect");
        quiet(); tick("exc_idle");

        // Vectored timer interrupt, then no retrigger while MIE is clear
        mie = 1'b1; mtie = 1'b1; mtip = 1'b1; mtvec = 32'h0000_1000; pc = 32'h0000_0208;
        tick("tmr_mepc");
        junk(); tick("tmr_mcause");
        junk(); tick("tmr_mtval");
        junk(); tick("tmr_redirect");
        quiet(); mtie = 1'b1; mtip = 1'b1;
        tick("tmr_no_retrigger");
        tick("tmr_no_retrigger2");

        // Exception beats all interrupts; interrupt beats MRET
        mie = 1'b1; meie = 1'b1; msie = 1'b1; mtie = 1'b1;
        meip = 1'b1; msip = 1'b1; mtip = 1'b1;
        exc_valid = 1'b1; exc_cause = 4'd6; exc_tval = 32'hDEAD_BEEF; pc = 32'h0000_0300;
        tick("prio_exc_mepc");
        tick("prio_exc_mcause");
        tick("prio_exc_mtval");
        tick("prio_exc_redirect");
        exc_valid = 1'b0; mret = 1'b1;
        tick("prio_idle");
        tick("prio_irq_mepc");
        tick("prio_irq_mcause");
        tick("prio_irq_mtval");
        tick("prio_irq_redirect");
        quiet(); tick("prio_irq_idle");

        // MRET
        mret = 1'b1; mepc = 32'h0000_0403;
        tick("mret_ret");
        quiet(); tick("mret_idle");

        // Reset in W_CAUSE abandons the sequence
        exc_valid = 1'b1; exc_cause = 4'd4; exc_tval = 32'h1234_5678; pc = 32'h0000_0500;
        tick("rst_mepc");
        quiet(); tick("rst_mcause");
        rst = 1'b1; tick("rst_apply");
        rst = 1'b0; tick("rst_no_mtval");
        exc_valid = 1'b1; exc_cause = 4'd0; exc_tval = 32'h0000_0777; pc = 32'h0000_0600;
        tick("fresh_mepc");
        junk(); tick("fresh_mcause");
        junk(); tick("fresh_mtval");
        junk(); tick("fresh_redirect");

        // Held request is accepted again in the first IDLE cycle
        quiet(); mie = 1'b1; msie = 1'b1; msip = 1'b1; pc = 32'h0000_0700;
        for (int i = 0; i < 12; i++) tick("b2b");

        // Randomized traffic with occasional resets
        quiet();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                quiet();
                rst = 1'b1;
            end else begin
                rst = 1'b0;
                if (idle_now) random_event();
                else junk();
            end
            tick("random");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
